note_frame_player: RTL

Byte-to-note sequencer between the UART receiver and the beeper driver. It assembles received byte pairs into (tone, duration) note frames and buffers them in a small FIFO. It then plays them back one at a time, timed by the system 1 ms tick. The `music_tone` output drives the beeper's tone input directly; tone 0 is a rest.

---
 rtl/note_pkg.sv | 25 ++
 rtl/note_frame_player_if.sv | 16 +
 rtl/note_fifo.sv | 50 +++++
 rtl/note_frame_player.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared types for the note frame player.
// Player/assembler states, the note frame layout and the rest tone code.
package note_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        NEXT
    } play_state_t;

    typedef enum logic {
        WAIT_TONE,
        WAIT_DUR
    } asm_state_t;

    typedef struct packed {
        logic [7:0] tone;
        logic [7:0] dur;
    } note_frame_t;

    localparam logic [7:0] TONE_REST = 8'd0;

endpackage

// File: rtl/note_frame_player_if.sv
// Received-byte stream from the UART receiver into the note player.
// The master is the UART side, the slave is the player.
interface note_frame_player_if;
    logic       uart_done;
    logic [7:0] uart_data;

    modport master (
        output uart_done,
        output uart_data
    );

    modport slave (
        input uart_done,
        input uart_data
    );
endinterface

// File: rtl/note_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a synchronous flush.
// Read data is the current head; a pop advances past it.
module note_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd = i_rd & ~o_empty;
    assign w_do_wr = i_wr & (~o_full | w_do_rd);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush empties the FIFO in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate them.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_do_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/note_frame_player.sv
// Assembles UART byte pairs into note frames and plays them per 1 ms tick.
// Optional NOTE_GAP_EN inserts GAP_MS silent ticks after each played note.
module note_frame_player
    import note_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DUR_UNIT_MS = 10,
    parameter int TIMEOUT_MS  = 50,
    parameter int GAP_MS      = 5
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                tick_1ms,
    note_frame_player_if.slave  uart,
    input  logic                music_stop,
    output logic [7:0]          music_tone,
    output logic                busy,
    output logic                fifo_full,
    output logic                overflow
);

    localparam int TW = $clog2(TIMEOUT_MS + 1);

    logic        r_tick_q;
    logic        w_tick;

    asm_state_t  r_asm;
    asm_state_t  w_asm_next;
    logic [7:0]  r_tone_byte;
    logic [TW-1:0] r_to_cnt;
    logic        w_timeout;
    logic        w_wr;
    note_frame_t w_frame;

    logic [15:0] w_rdata;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_drop;

    play_state_t r_state;
    play_state_t w_next;
    note_frame_t r_frame;
    logic [15:0] r_remaining;
    logic [7:0]  r_music_tone;
    logic [7:0]  w_tone_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_overflow;

`ifdef NOTE_GAP_EN
    localparam int GW = $clog2(GAP_MS + 1);
    logic [GW-1:0] r_gap_cnt;
`endif

    // Edge detect on the free-running millisecond level.
    always_ff @(posedge sys_clk) begin
        r_tick_q <= tick_1ms;
    end

    assign w_tick = tick_1ms & ~r_tick_q;

    // Assembler state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_asm <= WAIT_TONE;
        else         r_asm <= w_asm_next;
    end

    assign w_timeout = (r_asm == WAIT_DUR) && w_tick &&
                       (r_to_cnt == TW'(TIMEOUT_MS - 1));

    // Assembler next state; a stale tone byte times out to resync framing.
    always_comb begin
        w_asm_next = r_asm;
        if (music_stop) begin
            w_asm_next = WAIT_TONE;
        end else begin
            unique case (r_asm)
                WAIT_TONE: if (uart.uart_done) w_asm_next = WAIT_DUR;
                WAIT_DUR:  if (uart.uart_done || w_timeout)
                               w_asm_next = WAIT_TONE;
                default:   w_asm_next = WAIT_TONE;
            endcase
        end
    end

    // Assembler outputs: the completed frame and its write strobe.
    always_comb begin
        w_wr         = ~music_stop & (r_asm == WAIT_DUR) & uart.uart_done;
        w_frame.tone = r_tone_byte;
        w_frame.dur  = uart.uart_data;
    end

    // Assembler datapath: held tone byte and timeout tick counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tone_byte <= '0;
            r_to_cnt    <= '0;
        end else if (!music_stop) begin
            if (r_asm == WAIT_TONE && uart.uart_done) begin
                r_tone_byte <= uart.uart_data;
                r_to_cnt    <= '0;
            end else if (r_asm == WAIT_DUR && w_tick) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_flush (music_stop),
        .i_wr    (w_wr),
        .i_wdata (w_frame),
        .i_rd    (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_drop = w_wr & w_full & ~w_pop;

    // Player state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Player next state; stop overrides everything.
    always_comb begin
        w_next = r_state;
        if (music_stop) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (!w_empty) w_next = LOAD;
                LOAD: w_next = (r_frame.dur == 8'd0) ? NEXT : PLAY;
                PLAY: begin
                    if (w_tick && r_remaining == 16'd1) begin
`ifdef NOTE_GAP_EN
                        w_next = GAP;
`else
                        w_next = NEXT;
`endif
                    end
                end
`ifdef NOTE_GAP_EN
                GAP:  if (w_tick && r_gap_cnt == GW'(1)) w_next = NEXT;
`endif
                NEXT: w_next = w_empty ? IDLE : LOAD;
                default: w_next = IDLE;
            endcase
        end
    end

    // Player outputs; the tone is held across NEXT/LOAD so
    // back-to-back notes do not drop to silence between them.
    always_comb begin
        w_pop = ~music_stop & ~w_empty &
                ((r_state == IDLE) | (r_state == NEXT));
        w_busy_next = ~music_stop & ((r_state != IDLE) | ~w_empty);
        unique case (w_next)
            PLAY:       w_tone_next = r_frame.tone;
            LOAD, NEXT: w_tone_next = r_music_tone;
            default:    w_tone_next = TONE_REST;
        endcase
    end

    // Player datapath: popped frame and note/gap countdowns.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_frame     <= '0;
            r_remaining <= '0;
        end else begin
            if (w_pop) r_frame <= note_frame_t'(w_rdata);
            if (r_state == LOAD)
                r_remaining <= 16'(r_frame.dur) * 16'(DUR_UNIT_MS);
            else if (r_state == PLAY && w_tick)
                r_remaining <= r_remaining - 16'd1;
        end
    end

`ifdef NOTE_GAP_EN
    // Gap countdown loaded as a note finishes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            r_gap_cnt <= '0;
        else if (r_state == PLAY && w_next == GAP)
            r_gap_cnt <= GW'(GAP_MS);
        else if (r_state == GAP && w_tick)
            r_gap_cnt <= r_gap_cnt - GW'(1);
    end
`endif

    // Registered outputs; overflow is sticky until stop or reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_music_tone <= TONE_REST;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_music_tone <= w_tone_next;
            r_busy       <= w_busy_next;
            if (music_stop)  r_overflow <= 1'b0;
            else if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign music_tone = r_music_tone;
    assign busy       = r_busy;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;

endmodule
